// File: rtl/voting_machine_param.sv
// Parametrised ballot counter: N_CAND one-hot candidates, debounced
// one-vote-per-press capture, invalid-ballot counting, saturating counters
// and a sequential winner scan that runs when the booth enters result mode.
module voting_machine_param #(
  parameter int N_CAND = 4,
  parameter int CNT_W  = 8,
  parameter int HOLD   = 3
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [N_CAND-1:0]         candidate,
  input  logic                      mode,
  input  logic                      button,
  output logic                      vote_ok,
  output logic                      vote_bad,
  output logic [CNT_W-1:0]          count_out,
  output logic [CNT_W-1:0]          total_out,
  output logic [CNT_W-1:0]          invalid_out,
  output logic [$clog2(N_CAND)-1:0] winner,
  output logic                      tie,
  output logic                      result_valid,
  output logic                      sat
);

  localparam int IDX_W = $clog2(N_CAND);
  localparam int HC_W  = $clog2(HOLD + 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
  localparam logic [HC_W-1:0]  HOLD_LAST = HC_W'(HOLD - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(N_CAND - 1);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_HOLDING  = 3'd1;
  localparam logic [2:0] S_CAPTURE  = 3'd2;
  localparam logic [2:0] S_WAIT_REL = 3'd3;
  localparam logic [2:0] S_RESULT   = 3'd4;
  localparam logic [2:0] S_SCAN     = 3'd5;
  localparam logic [2:0] S_SHOW     = 3'd6;

  // True when exactly one bit of the ballot is set.
  function automatic logic is_onehot(input logic [N_CAND-1:0] v);
    logic seen;
    logic multi;
    seen  = 1'b0;
    multi = 1'b0;
    for (int i = 0; i < N_CAND; i++) begin
      if (v[i]) begin
        if (seen) multi = 1'b1;
        else      seen  = 1'b1;
      end
    end
    return seen & ~multi;
  endfunction

  // Index of the set bit of a one-hot vector (0 when none set).
  function automatic logic [IDX_W-1:0] onehot_idx(input logic [N_CAND-1:0] v);
    logic [IDX_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < N_CAND; i++) begin
      if (v[i]) idx = IDX_W'(i);
    end
    return idx;
  endfunction

  logic [2:0]        state_r, state_s;
  logic [HC_W-1:0]   hold_cnt_r, hold_cnt_s;
  logic [N_CAND-1:0] latch_r, latch_s;
  logic [CNT_W-1:0]  cnt_r [N_CAND];
  logic [CNT_W-1:0]  total_r, invalid_r, count_out_r;
  logic              vote_ok_r, vote_bad_r, sat_r;
  logic [IDX_W-1:0]  scan_idx_r, scan_win_r, winner_r;
  logic [CNT_W-1:0]  scan_max_r;
  logic              scan_tie_r, tie_r, result_valid_r;
  logic              capture_go_s, scan_last_s;
  logic [CNT_W-1:0]  scan_cur_s, scan_max_s;
  logic [IDX_W-1:0]  scan_win_s;
  logic              scan_tie_s;
  logic [2:0]        leave_result_s;

  // Next-state logic for the booth FSM plus the debounce latch and counter.
  always_comb begin
    state_s    = state_r;
    hold_cnt_s = hold_cnt_r;
    latch_s    = latch_r;
    leave_result_s = button ? S_WAIT_REL : S_IDLE;
    case (state_r)
      S_IDLE: begin
        if (mode) begin
          state_s = S_RESULT;
        end else if (button) begin
          state_s    = S_HOLDING;
          latch_s    = candidate;
          hold_cnt_s = HC_W'(1);
        end else begin
          state_s = S_IDLE;
        end
      end
      S_HOLDING: begin
        if (mode) begin
          state_s = S_RESULT;
        end else if (!button) begin
          state_s    = S_IDLE;
          hold_cnt_s = '0;
        end else if (candidate != latch_r) begin
          latch_s    = candidate;
          hold_cnt_s = HC_W'(1);
        end else if (hold_cnt_r >= HOLD_LAST) begin
          state_s = S_CAPTURE;
        end else begin
          hold_cnt_s = hold_cnt_r + 1'b1;
        end
      end
      S_CAPTURE: begin
        if (mode) state_s = S_RESULT;
        else      state_s = S_WAIT_REL;
        hold_cnt_s = '0;
      end
      S_WAIT_REL: begin
        if (mode)         state_s = S_RESULT;
        else if (!button) state_s = S_IDLE;
        else              state_s = S_WAIT_REL;
      end
      S_RESULT: begin
        if (!mode) state_s = leave_result_s;
        else       state_s = S_SCAN;
      end
      S_SCAN: begin
        if (!mode)                      state_s = leave_result_s;
        else if (scan_idx_r == IDX_LAST) state_s = S_SHOW;
        else                            state_s = S_SCAN;
      end
      S_SHOW: begin
        if (!mode) state_s = leave_result_s;
        else       state_s = S_SHOW;
      end
      default: begin
        state_s    = S_IDLE;
        hold_cnt_s = '0;
      end
    endcase
    capture_go_s = (state_r == S_HOLDING) && (state_s == S_CAPTURE);
  end

  // One comparison step of the winner scan; strict '>' keeps the lowest index.
  always_comb begin
    scan_cur_s  = cnt_r[scan_idx_r];
    scan_last_s = (state_r == S_SCAN) && (scan_idx_r == IDX_LAST);
    if (scan_cur_s > scan_max_r) begin
      scan_max_s = scan_cur_s;
      scan_win_s = scan_idx_r;
      scan_tie_s = 1'b0;
    end else if (scan_cur_s == scan_max_r) begin
      scan_max_s = scan_max_r;
      scan_win_s = scan_win_r;
      scan_tie_s = 1'b1;
    end else begin
      scan_max_s = scan_max_r;
      scan_win_s = scan_win_r;
      scan_tie_s = scan_tie_r;
    end
  end

  // FSM state, debounce registers and the capture pulses.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= S_IDLE;
      hold_cnt_r <= '0;
      latch_r    <= '0;
      vote_ok_r  <= 1'b0;
      vote_bad_r <= 1'b0;
    end else begin
      state_r    <= state_s;
      hold_cnt_r <= hold_cnt_s;
      latch_r    <= latch_s;
      vote_ok_r  <= capture_go_s &  is_onehot(latch_r);
      vote_bad_r <= capture_go_s & ~is_onehot(latch_r);
    end
  end

  // Saturating vote, total and invalid counters, committed in CAPTURE.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < N_CAND; i++) cnt_r[i] <= '0;
      total_r   <= '0;
      invalid_r <= '0;
      sat_r     <= 1'b0;
    end else if ((state_r == S_CAPTURE) && !mode) begin
      if (is_onehot(latch_r)) begin
        for (int i = 0; i < N_CAND; i++) begin
          if (latch_r[i]) begin
            if (cnt_r[i] == CNT_MAX) sat_r    <= 1'b1;
            else                     cnt_r[i] <= cnt_r[i] + 1'b1;
          end
        end
        if (total_r == CNT_MAX) sat_r   <= 1'b1;
        else                    total_r <= total_r + 1'b1;
      end else begin
        if (invalid_r == CNT_MAX) sat_r     <= 1'b1;
        else                      invalid_r <= invalid_r + 1'b1;
      end
    end else begin
      sat_r <= sat_r;
    end
  end

  // Winner scan: RESULT seeds with candidate 0, SCAN walks the rest.
  always_ff @(posedge clk) begin
    if (reset) begin
      scan_idx_r     <= '0;
      scan_max_r     <= '0;
      scan_win_r     <= '0;
      scan_tie_r     <= 1'b0;
      winner_r       <= '0;
      tie_r          <= 1'b0;
      result_valid_r <= 1'b0;
    end else begin
      result_valid_r <= mode && ((state_r == S_SHOW) || scan_last_s);
      if ((state_r == S_RESULT) && mode) begin
        scan_max_r <= cnt_r[0];
        scan_win_r <= '0;
        scan_tie_r <= 1'b0;
        scan_idx_r <= IDX_W'(1);
      end else if ((state_r == S_SCAN) && mode) begin
        scan_max_r <= scan_max_s;
        scan_win_r <= scan_win_s;
        scan_tie_r <= scan_tie_s;
        if (scan_last_s) begin
          winner_r <= scan_win_s;
          tie_r    <= scan_tie_s;
        end else begin
          scan_idx_r <= scan_idx_r + 1'b1;
        end
      end else begin
        scan_idx_r <= scan_idx_r;
      end
    end
  end

  // Display mux: selected count in result mode, zero otherwise.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_out_r <= '0;
    end else if (mode && is_onehot(candidate)) begin
      count_out_r <= cnt_r[onehot_idx(candidate)];
    end else begin
      count_out_r <= '0;
    end
  end

  assign vote_ok      = vote_ok_r;
  assign vote_bad     = vote_bad_r;
  assign count_out    = count_out_r;
  assign total_out    = total_r;
  assign invalid_out  = invalid_r;
  assign winner       = winner_r;
  assign tie          = tie_r;
  assign result_valid = result_valid_r;
  assign sat          = sat_r;

endmodule

// File: tb/tb_voting_machine_param.sv
// Directed bench for voting_machine_param: a default instance (CNT_W=8)
// and a narrow instance (CNT_W=2) share clock, reset and inputs.
module tb_voting_machine_param;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] candidate = 4'b0000;
  logic       mode = 1'b0;
  logic       button = 1'b0;

  logic       vote_ok, vote_bad, tie, result_valid, sat;
  logic [7:0] count_out, total_out, invalid_out;
  logic [1:0] winner;
  logic       vote_ok2, vote_bad2, tie2, result_valid2, sat2;
  logic [1:0] count_out2, total_out2, invalid_out2;
  logic [1:0] winner2;

  int checks = 0;
  int fails  = 0;
  int ok_cnt, bad_cnt, ok_at, ok2_cnt, ok2_at;

  always #5 clk = ~clk;

  voting_machine_param #(.N_CAND(4), .CNT_W(8), .HOLD(3)) dut (
    .clk(clk), .reset(reset), .candidate(candidate), .mode(mode), .button(button),
    .vote_ok(vote_ok), .vote_bad(vote_bad), .count_out(count_out),
    .total_out(total_out), .invalid_out(invalid_out), .winner(winner),
    .tie(tie), .result_valid(result_valid), .sat(sat));

  voting_machine_param #(.N_CAND(4), .CNT_W(2), .HOLD(3)) dut2 (
    .clk(clk), .reset(reset), .candidate(candidate), .mode(mode), .button(button),
    .vote_ok(vote_ok2), .vote_bad(vote_bad2), .count_out(count_out2),
    .total_out(total_out2), .invalid_out(invalid_out2), .winner(winner2),
    .tie(tie2), .result_valid(result_valid2), .sat(sat2));

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; mode = 1'b0; button = 1'b0; candidate = 4'b0000;
    cyc(); cyc();
    reset = 1'b0;
  endtask

  // Button high for n cycles (candidate c, switching to c2 after sw cycles),
  // then low for tail cycles; pulses are counted with the cycle they appear in.
  task automatic press(input logic [3:0] c, input logic [3:0] c2, input int sw,
                       input int n, input int tail);
    ok_cnt = 0; bad_cnt = 0; ok_at = 0; ok2_cnt = 0; ok2_at = 0;
    candidate = c; button = 1'b1;
    for (int k = 1; k <= n + tail; k++) begin
      if (sw > 0 && k == sw + 1) candidate = c2;
      if (k == n + 1) button = 1'b0;
      cyc();
      if (vote_ok)  begin ok_cnt++;  ok_at = k;  end
      if (vote_bad) bad_cnt++;
      if (vote_ok2) begin ok2_cnt++; ok2_at = k; end
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (total_out !== 8'd0) begin fails++; $display("FAIL rst_total got=%0d exp=0", total_out); end
    checks++; if (invalid_out !== 8'd0) begin fails++; $display("FAIL rst_invalid got=%0d exp=0", invalid_out); end
    checks++; if ({vote_ok, vote_bad, sat, tie, result_valid} !== 5'b00000) begin fails++; $display("FAIL rst_flags got=%b exp=00000", {vote_ok, vote_bad, sat, tie, result_valid}); end
    checks++; if (winner !== 2'd0 || count_out !== 8'd0) begin fails++; $display("FAIL rst_winner_count got=%0d/%0d exp=0/0", winner, count_out); end
  endtask

  task automatic test_single_vote();
    press(4'b0001, 4'b0001, 0, 5, 4);
    checks++; if (ok_cnt !== 1 || ok_at !== 3) begin fails++; $display("FAIL t1_pulse got cnt=%0d at=%0d exp cnt=1 at=3", ok_cnt, ok_at); end
    checks++; if (bad_cnt !== 0) begin fails++; $display("FAIL t1_bad got=%0d exp=0", bad_cnt); end
    checks++; if (total_out !== 8'd1) begin fails++; $display("FAIL t1_total got=%0d exp=1", total_out); end
  endtask

  task automatic test_cand_change();
    press(4'b0010, 4'b0100, 2, 6, 4);
    checks++; if (ok_cnt !== 1 || ok_at !== 5) begin fails++; $display("FAIL t2_pulse got cnt=%0d at=%0d exp cnt=1 at=5", ok_cnt, ok_at); end
    checks++; if (total_out !== 8'd2) begin fails++; $display("FAIL t2_total got=%0d exp=2", total_out); end
    mode = 1'b1; candidate = 4'b0100; cyc();
    checks++; if (count_out !== 8'd1) begin fails++; $display("FAIL t2_cnt2 got=%0d exp=1", count_out); end
    candidate = 4'b0010; cyc();
    checks++; if (count_out !== 8'd0) begin fails++; $display("FAIL t2_cnt1 got=%0d exp=0", count_out); end
    candidate = 4'b0001; cyc();
    checks++; if (count_out !== 8'd1) begin fails++; $display("FAIL t2_cnt0 got=%0d exp=1", count_out); end
    mode = 1'b0; candidate = 4'b0000; cyc();
    checks++; if (result_valid !== 1'b0 || count_out !== 8'd0) begin fails++; $display("FAIL t2_exit got rv=%b cnt=%0d exp rv=0 cnt=0", result_valid, count_out); end
  endtask

  task automatic test_invalid();
    press(4'b0011, 4'b0011, 0, 4, 4);
    checks++; if (bad_cnt !== 1 || ok_cnt !== 0) begin fails++; $display("FAIL t3_pulse got bad=%0d ok=%0d exp bad=1 ok=0", bad_cnt, ok_cnt); end
    checks++; if (invalid_out !== 8'd1 || total_out !== 8'd2) begin fails++; $display("FAIL t3_counts got inv=%0d tot=%0d exp inv=1 tot=2", invalid_out, total_out); end
  endtask

  task automatic test_short_press();
    press(4'b0001, 4'b0001, 0, 2, 4);
    checks++; if (ok_cnt !== 0 || bad_cnt !== 0) begin fails++; $display("FAIL t4_pulse got ok=%0d bad=%0d exp 0/0", ok_cnt, bad_cnt); end
    checks++; if (total_out !== 8'd2 || invalid_out !== 8'd1) begin fails++; $display("FAIL t4_counts got tot=%0d inv=%0d exp tot=2 inv=1", total_out, invalid_out); end
  endtask

  task automatic test_all_zero();
    do_reset();
    mode = 1'b1;
    for (int k = 1; k <= 5; k++) cyc();
    checks++; if (result_valid !== 1'b1 || winner !== 2'd0 || tie !== 1'b1) begin fails++; $display("FAIL zero_scan got rv=%b win=%0d tie=%b exp rv=1 win=0 tie=1", result_valid, winner, tie); end
    mode = 1'b0; cyc();
  endtask

  task automatic test_winner_scan();
    logic [3:0] seq [6];
    seq[0] = 4'b0001; seq[1] = 4'b0010; seq[2] = 4'b0010;
    seq[3] = 4'b0100; seq[4] = 4'b0100; seq[5] = 4'b1000;
    do_reset();
    for (int v = 0; v < 6; v++) press(seq[v], seq[v], 0, 5, 2);
    checks++; if (total_out !== 8'd6) begin fails++; $display("FAIL t5_total got=%0d exp=6", total_out); end
    mode = 1'b1; candidate = 4'b0000;
    for (int k = 1; k <= 5; k++) begin
      cyc();
      if (k == 4) begin
        checks++; if (result_valid !== 1'b0) begin fails++; $display("FAIL t5_rv_early got=%b exp=0", result_valid); end
      end
    end
    checks++; if (result_valid !== 1'b1) begin fails++; $display("FAIL t5_rv got=%b exp=1", result_valid); end
    checks++; if (winner !== 2'd1 || tie !== 1'b1) begin fails++; $display("FAIL t5_winner got win=%0d tie=%b exp win=1 tie=1", winner, tie); end
    candidate = 4'b0100; cyc();
    checks++; if (count_out !== 8'd2) begin fails++; $display("FAIL t5_cnt2 got=%0d exp=2", count_out); end
    candidate = 4'b0000; cyc();
    checks++; if (count_out !== 8'd0) begin fails++; $display("FAIL t5_cnt_none got=%0d exp=0", count_out); end
    candidate = 4'b1000; cyc();
    checks++; if (count_out !== 8'd1) begin fails++; $display("FAIL t5_cnt3 got=%0d exp=1", count_out); end
    mode = 1'b0; candidate = 4'b0000; cyc();
    checks++; if (result_valid !== 1'b0 || winner !== 2'd1 || tie !== 1'b1) begin fails++; $display("FAIL t5_hold got rv=%b win=%0d tie=%b exp rv=0 win=1 tie=1", result_valid, winner, tie); end
  endtask

  task automatic test_saturation_reset();
    do_reset();
    for (int v = 0; v < 4; v++) press(4'b0001, 4'b0001, 0, 5, 2);
    checks++; if (ok2_cnt !== 1) begin fails++; $display("FAIL t6_sat_pulse got=%0d exp=1", ok2_cnt); end
    checks++; if (total_out2 !== 2'd3 || sat2 !== 1'b1) begin fails++; $display("FAIL t6_sat got tot=%0d sat=%b exp tot=3 sat=1", total_out2, sat2); end
    checks++; if (sat !== 1'b0 || total_out !== 8'd4) begin fails++; $display("FAIL t6_wide got sat=%b tot=%0d exp sat=0 tot=4", sat, total_out); end
    mode = 1'b1; candidate = 4'b0001; cyc();
    checks++; if (count_out2 !== 2'd3) begin fails++; $display("FAIL t6_cnt0 got=%0d exp=3", count_out2); end
    mode = 1'b0; candidate = 4'b0010; cyc();
    button = 1'b1; cyc(); cyc();
    reset = 1'b1; button = 1'b0; cyc();
    reset = 1'b0;
    checks++; if (total_out2 !== 2'd0 || sat2 !== 1'b0 || invalid_out2 !== 2'd0 || vote_ok2 !== 1'b0) begin fails++; $display("FAIL t6_reset got tot=%0d sat=%b inv=%0d ok=%b exp all 0", total_out2, sat2, invalid_out2, vote_ok2); end
    checks++; if (total_out !== 8'd0) begin fails++; $display("FAIL t6_reset_wide got=%0d exp=0", total_out); end
    press(4'b0010, 4'b0010, 0, 5, 3);
    checks++; if (ok2_cnt !== 1 || ok2_at !== 3 || total_out2 !== 2'd1) begin fails++; $display("FAIL t6_after got cnt=%0d at=%0d tot=%0d exp 1/3/1", ok2_cnt, ok2_at, total_out2); end
  endtask

  initial begin
    test_reset();
    test_single_vote();
    test_cand_change();
    test_invalid();
    test_short_press();
    test_all_zero();
    test_winner_scan();
    test_saturation_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
